render_map_seq: RTL and testbench
=================================

Name: render_map_seq

Overview:
- Handshaked, parametrised tile-map renderer. It replaces the free-running clock-divided grid scanner.
- On `start` it walks every map cell, reads the cell's tile id and dirty flag from map RAM, and blits the tile's pixels from the tile ROM into the framebuffer.
- It sits between the game-state map RAM and the framebuffer write port.
- It adds: a dirty-only redraw mode, a colour-key (transparent) mode, destination backpressure, and start/busy/done sequencing.

Parameters:
- MAP_W, 20, map width in cells
- MAP_H, 15, map height in cells
- TILE_LOG2, 5, log2 of the tile edge in pixels (T = 1<<TILE_LOG2)
- FB_W, 640, framebuffer row pitch in pixels
- ADDR_W, 19, width of the src/dst address
- ID_W, 9, width of the tile id
- PIX_W, 16, pixel width
- CELL_W, 9, width of the map cell index; must satisfy 2^CELL_W >= MAP_W*MAP_H
- KEY_COLOR, 16'hF81F, transparent pixel value

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to render the whole map
- mode_dirty  in  1  sampled at start; 1 = draw only dirty cells
- key_en  in  1  sampled at start; 1 = suppress writes of KEY_COLOR pixels
- busy  out  1  render in progress
- done  out  1  one-cycle pulse at completion
- map_addr  out  CELL_W  cell index = gy*MAP_W+gx
- map_rd  out  1  map read strobe; data valid next cycle
- map_tile_id  in  ID_W  tile id of the addressed cell
- map_dirty  in  1  dirty flag of the addressed cell
- dirty_clr  out  1  pulse: clear the dirty flag at map_addr
- src_addr  out  ADDR_W  tile ROM address
- src_rd  out  1  ROM read strobe; src_data valid next cycle
- src_data  in  PIX_W  ROM pixel
- dst_addr  out  ADDR_W  framebuffer address
- dst_data  out  PIX_W  framebuffer pixel
- dst_wr  out  1  write valid
- dst_ready  in  1  framebuffer accepts the write when dst_wr and dst_ready are both high

Behaviour:
- Reset: all outputs 0; the FSM goes to IDLE. A reset mid-render aborts with no done pulse; outputs are 0 after the next edge.
- FSM states and transitions:
  - IDLE: on start go to FETCH, with gx=gy=0 and mode_dirty/key_en latched. start while not in IDLE is ignored.
  - FETCH: map_rd=1 for 1 cycle, then go to WAIT.
  - WAIT: capture map_tile_id and map_dirty.
    - If the latched mode_dirty is set and map_dirty=0, go to NEXT.
    - Otherwise go to BLIT.
  - BLIT: px/py counters sweep 0..T-1, row-major.
    - src_addr = (id<<(2*TILE_LOG2)) + (py<<TILE_LOG2) + px.
    - src_rd = (pixels remain) && (!dst_wr || dst_ready).
    - The cycle after a read: dst_wr=1, dst_data=src_data, dst_addr=((gy<<TILE_LOG2)+py)*FB_W + (gx<<TILE_LOG2)+px. Addresses are truncated to ADDR_W (modulo).
    - While dst_ready=0, dst_wr/dst_addr/dst_data hold stable and no read is issued. Pixels are never lost or duplicated.
    - If key_en and src_data==KEY_COLOR, dst_wr stays 0 for that pixel and the slot is free.
    - Leave BLIT once all T*T pixels have been read and the output stage is empty or accepted. In dirty mode, dirty_clr=1 for exactly the exit cycle, with map_addr equal to the current cell.
  - NEXT: gx+1. At gx=MAP_W-1, gx wraps to 0 and gy increments. At the last cell go to DONE, otherwise go to FETCH.
  - DONE: done=1, busy=0 for 1 cycle, then go to IDLE.
- busy=1 in every state except IDLE and DONE, so it rises the cycle after start.
- Timing with dst_ready held high:
  - a drawn cell takes T*T+4 cycles;
  - a skipped cell takes 3 cycles;
  - throughput is 1 pixel/cycle.

Decomposition:
- Package render_pkg: MAP_W, MAP_H, TILE_LOG2, FB_W, ADDR_W, ID_W, PIX_W, CELL_W, KEY_COLOR defaults, plus the FSM state encoding.
- One sub-module, tile_blit. It contains the px/py counters, src read/dst write stage, backpressure and colour key. Its interface is start/tile id/top/left in and blit_done out. The top-level module keeps the grid FSM and map/dirty handling.

Test Plan:
All tests use TILE_LOG2=1 (T=2), MAP_W=MAP_H=2, FB_W=8, and a ROM with src_data = src_addr.
- Full render, dst_ready=1: map ids {3,1,0,2}, start -> exactly 16 writes. Cell (1,0), pixel (0,0) gives src_addr=4, dst_addr=2. busy lasts 32 cycles, then done pulses once.
- Dirty mode: only cell 2 dirty (id 0) -> 4 writes to dst_addr 16,17,24,25. One dirty_clr pulse with map_addr=2. busy lasts 17 cycles.
- Backpressure: drop dst_ready for 3 cycles mid-tile -> dst_wr/dst_addr/dst_data stable, src_rd=0 during the stall. The final write set is identical to the no-stall run.
- Colour key: key_en=1 and ROM returns KEY_COLOR at address 1 -> that pixel is not written. All other pixels are written, and the cycle count is unchanged.
- Reset mid-BLIT: assert rst during the second cell -> next cycle busy=0, dst_wr=0, no done. A following start performs a complete render.
- start while busy: pulse start at the 5th busy cycle -> ignored; exactly one done pulse and 16 writes.

Source files
------------

// File: rtl/render_pkg.sv
// Shared defaults and grid FSM encoding for the tile-map renderer.
package render_pkg;

  localparam int unsigned DefMapW     = 20;
  localparam int unsigned DefMapH     = 15;
  localparam int unsigned DefTileLog2 = 5;
  localparam int unsigned DefFbW      = 640;
  localparam int unsigned DefAddrW    = 19;
  localparam int unsigned DefIdW      = 9;
  localparam int unsigned DefPixW     = 16;
  localparam int unsigned DefCellW    = 9;
  localparam logic [15:0] DefKeyColor = 16'hF81F;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StBlit,
    StNext,
    StDone
  } grid_state_e;

endpackage

// File: rtl/tile_blit.sv
// Copies one T x T tile from the tile ROM to the framebuffer, one pixel per
// cycle. Holds at most one pixel in flight so backpressure never drops or
// duplicates a pixel; keyed pixels free their slot without a write.
module tile_blit import render_pkg::*; #(
  parameter int unsigned      TILE_LOG2 = DefTileLog2,
  parameter int unsigned      FB_W      = DefFbW,
  parameter int unsigned      ADDR_W    = DefAddrW,
  parameter int unsigned      ID_W      = DefIdW,
  parameter int unsigned      PIX_W     = DefPixW,
  parameter logic [PIX_W-1:0] KEY_COLOR = DefKeyColor
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blit_start,
  input  logic [ID_W-1:0]   tile_id,
  input  logic [ADDR_W-1:0] top,
  input  logic [ADDR_W-1:0] left,
  input  logic              key_en,
  output logic              blit_done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_wr,
  input  logic              dst_ready
);

  // Extra MSB on the read counter flags "all T*T pixels read".
  localparam int unsigned CntW = 2 * TILE_LOG2 + 1;

  logic [CntW-1:0]      rd_cnt_q, rd_cnt_d;
  logic                 active_q, active_d;
  logic                 fresh_q, fresh_d;   // read issued last cycle, src_data live
  logic                 held_q, held_d;     // stalled write parked in held_data_q
  logic [PIX_W-1:0]     held_data_q, held_data_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]    top_q, top_d, left_q, left_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [TILE_LOG2-1:0] px, py;
  logic                 all_read, slot_free, keyed;
  logic [ADDR_W-1:0]    rd_dst_addr;

  assign px       = rd_cnt_q[TILE_LOG2-1:0];
  assign py       = rd_cnt_q[2*TILE_LOG2-1:TILE_LOG2];
  assign all_read = rd_cnt_q[CntW-1];

  // Output stage, read issue and completion decode.
  always_comb begin
    keyed       = key_en && (src_data == KEY_COLOR);
    dst_data    = fresh_q ? src_data : held_data_q;
    dst_wr      = fresh_q ? !keyed : held_q;
    dst_addr    = wr_addr_q;
    slot_free   = !dst_wr || dst_ready;
    src_rd      = active_q && !all_read && slot_free;
    src_addr    = (ADDR_W'(id_q) << (2 * TILE_LOG2)) + (ADDR_W'(py) << TILE_LOG2)
                  + ADDR_W'(px);
    rd_dst_addr = (top_q + ADDR_W'(py)) * ADDR_W'(FB_W) + left_q + ADDR_W'(px);
    blit_done   = active_q && all_read && slot_free;
  end

  // Next-state for counters, in-flight pixel and latched tile parameters.
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    active_d    = active_q;
    fresh_d     = src_rd;
    held_d      = dst_wr && !dst_ready;
    held_data_d = held_data_q;
    wr_addr_d   = wr_addr_q;
    top_d       = top_q;
    left_d      = left_q;
    id_d        = id_q;
    if (dst_wr && !dst_ready) begin
      held_data_d = dst_data;
    end
    if (src_rd) begin
      rd_cnt_d  = rd_cnt_q + CntW'(1);
      wr_addr_d = rd_dst_addr;
    end
    if (blit_done) begin
      active_d = 1'b0;
    end
    if (blit_start) begin
      active_d = 1'b1;
      rd_cnt_d = '0;
      id_d     = tile_id;
      top_d    = top;
      left_d   = left;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      active_q    <= 1'b0;
      fresh_q     <= 1'b0;
      held_q      <= 1'b0;
      held_data_q <= '0;
      wr_addr_q   <= '0;
      top_q       <= '0;
      left_q      <= '0;
      id_q        <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      active_q    <= active_d;
      fresh_q     <= fresh_d;
      held_q      <= held_d;
      held_data_q <= held_data_d;
      wr_addr_q   <= wr_addr_d;
      top_q       <= top_d;
      left_q      <= left_d;
      id_q        <= id_d;
    end
  end

endmodule

// File: rtl/render_map_seq.sv
// Tile-map renderer top: walks the map grid, reads each cell, optionally skips
// clean cells, and hands drawn cells to tile_blit.
module render_map_seq import render_pkg::*; #(
  parameter int unsigned      MAP_W     = DefMapW,
  parameter int unsigned      MAP_H     = DefMapH,
  parameter int unsigned      TILE_LOG2 = DefTileLog2,
  parameter int unsigned      FB_W      = DefFbW,
  parameter int unsigned      ADDR_W    = DefAddrW,
  parameter int unsigned      ID_W      = DefIdW,
  parameter int unsigned      PIX_W     = DefPixW,
  parameter int unsigned      CELL_W    = DefCellW,
  parameter logic [PIX_W-1:0] KEY_COLOR = DefKeyColor
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_dirty,
  input  logic              key_en,
  output logic              busy,
  output logic              done,
  output logic [CELL_W-1:0] map_addr,
  output logic              map_rd,
  input  logic [ID_W-1:0]   map_tile_id,
  input  logic              map_dirty,
  output logic              dirty_clr,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_wr,
  input  logic              dst_ready
);

  grid_state_e       state_q, state_d;
  logic [CELL_W-1:0] gx_q, gx_d, gy_q, gy_d, cell_q, cell_d;
  logic              mode_dirty_q, mode_dirty_d;
  logic              key_en_q, key_en_d;
  logic              blit_start, blit_done, last_cell;
  logic [ADDR_W-1:0] blit_top, blit_left;

  // Pixel origin of the current cell.
  assign blit_top  = ADDR_W'(gy_q) << TILE_LOG2;
  assign blit_left = ADDR_W'(gx_q) << TILE_LOG2;
  assign last_cell = (gx_q == CELL_W'(MAP_W - 1)) && (gy_q == CELL_W'(MAP_H - 1));

  // Grid FSM next-state and strobes.
  always_comb begin
    state_d      = state_q;
    gx_d         = gx_q;
    gy_d         = gy_q;
    cell_d       = cell_q;
    mode_dirty_d = mode_dirty_q;
    key_en_d     = key_en_q;
    busy         = 1'b0;
    done         = 1'b0;
    map_rd       = 1'b0;
    dirty_clr    = 1'b0;
    blit_start   = 1'b0;
    map_addr     = cell_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StFetch;
          gx_d         = '0;
          gy_d         = '0;
          cell_d       = '0;
          mode_dirty_d = mode_dirty;
          key_en_d     = key_en;
        end
      end
      StFetch: begin
        busy    = 1'b1;
        map_rd  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (mode_dirty_q && !map_dirty) begin
          state_d = StNext;
        end else begin
          state_d    = StBlit;
          blit_start = 1'b1;
        end
      end
      StBlit: begin
        busy = 1'b1;
        if (blit_done) begin
          state_d   = StNext;
          dirty_clr = mode_dirty_q;
        end
      end
      StNext: begin
        busy    = 1'b1;
        cell_d  = cell_q + CELL_W'(1);
        state_d = last_cell ? StDone : StFetch;
        if (gx_q == CELL_W'(MAP_W - 1)) begin
          gx_d = '0;
          gy_d = gy_q + CELL_W'(1);
        end else begin
          gx_d = gx_q + CELL_W'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Grid state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gx_q         <= '0;
      gy_q         <= '0;
      cell_q       <= '0;
      mode_dirty_q <= 1'b0;
      key_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      cell_q       <= cell_d;
      mode_dirty_q <= mode_dirty_d;
      key_en_q     <= key_en_d;
    end
  end

  tile_blit #(
    .TILE_LOG2 (TILE_LOG2),
    .FB_W      (FB_W),
    .ADDR_W    (ADDR_W),
    .ID_W      (ID_W),
    .PIX_W     (PIX_W),
    .KEY_COLOR (KEY_COLOR)
  ) u_tile_blit (
    .clk        (clk),
    .rst        (rst),
    .blit_start (blit_start),
    .tile_id    (map_tile_id),
    .top        (blit_top),
    .left       (blit_left),
    .key_en     (key_en_q),
    .blit_done  (blit_done),
    .src_addr   (src_addr),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .dst_wr     (dst_wr),
    .dst_ready  (dst_ready)
  );

endmodule

// File: tb/tb_render_map_seq.sv
// Bench for render_map_seq on a 2x2 map of 2x2 tiles, FB pitch 8.
module tb_render_map_seq;

  localparam logic [15:0] Key = 16'hF81F;

  logic        clk, rst, start, mode_dirty, key_en;
  logic        busy, done, map_rd, dirty_clr, src_rd, dst_wr, dst_ready, map_dirty;
  logic [8:0]  map_addr, map_tile_id;
  logic [18:0] src_addr, dst_addr;
  logic [15:0] src_data, dst_data;

  render_map_seq #(
    .MAP_W     (2),
    .MAP_H     (2),
    .TILE_LOG2 (1),
    .FB_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode_dirty  (mode_dirty),
    .key_en      (key_en),
    .busy        (busy),
    .done        (done),
    .map_addr    (map_addr),
    .map_rd      (map_rd),
    .map_tile_id (map_tile_id),
    .map_dirty   (map_dirty),
    .dirty_clr   (dirty_clr),
    .src_addr    (src_addr),
    .src_rd      (src_rd),
    .src_data    (src_data),
    .dst_addr    (dst_addr),
    .dst_data    (dst_data),
    .dst_wr      (dst_wr),
    .dst_ready   (dst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map RAM and tile ROM models (one-cycle read latency).
  logic [8:0] ids [4];
  logic       dmask_m [4];
  always @(posedge clk) begin
    if (map_rd) begin
      map_tile_id <= ids[map_addr[1:0]];
      map_dirty   <= dmask_m[map_addr[1:0]];
    end
    if (src_rd) src_data <= (src_addr == 19'd1) ? Key : src_addr[15:0];
  end

  typedef struct {
    logic       md;
    logic       key;
    logic [3:0] dmask;
    int         exp_wr;
    int         exp_busy;
    int         exp_clr;
    int         exp_clr_addr;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] fb   [64];
  bit          fbw  [64];
  int          n_vec, n_err;
  int          wr_cnt, busy_cnt, done_cnt, clr_cnt, clr_addr;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Sample and log the current cycle, then advance to the next one.
  task automatic tick();
    #1;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (dirty_clr === 1'b1) begin
      clr_cnt++;
      clr_addr = int'(map_addr);
    end
    if (dst_wr === 1'b1 && dst_ready) begin
      fb[dst_addr[5:0]]  = dst_data;
      fbw[dst_addr[5:0]] = 1'b1;
      wr_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_render(input logic md, input logic key);
    for (int i = 0; i < 64; i++) begin
      fb[i]  = '0;
      fbw[i] = 1'b0;
    end
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; clr_cnt = 0; clr_addr = -1;
    mode_dirty = md;
    key_en     = key;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_render(input int extra);
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    check("done_seen", done_cnt, 1);
    for (int i = 0; i < extra; i++) tick();
  endtask

  task automatic wait_busy(input int n);
    for (int i = 0; i < 200 && busy_cnt < n; i++) tick();
    check("reach_busy_cycle", busy_cnt, n);
  endtask

  // Expected framebuffer from map ids, dirty mask and key mode.
  task automatic check_fb(input logic md, input logic key, input logic [3:0] dmask);
    int          bad, src, dst;
    logic [15:0] data;
    bit          ew;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      for (int py = 0; py < 2; py++) begin
        for (int px = 0; px < 2; px++) begin
          src  = int'(ids[c]) * 4 + py * 2 + px;
          data = (src == 1) ? Key : 16'(src);
          ew   = (!md || dmask[c]) && !(key && data == Key);
          dst  = ((c / 2) * 2 + py) * 8 + (c % 2) * 2 + px;
          if (fbw[dst] != ew) bad++;
          else if (ew && fb[dst] != data) bad++;
        end
      end
    end
    check("fb_contents", bad, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; mode_dirty = 1'b0; key_en = 1'b0; dst_ready = 1'b1;
    ids[0] = 9'd3; ids[1] = 9'd1; ids[2] = 9'd0; ids[3] = 9'd2;
    for (int i = 0; i < 4; i++) dmask_m[i] = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 4'b0000, 16, 32, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 4'b0100,  4, 17, 1, 2};
    vecs[2] = '{1'b0, 1'b1, 4'b0000, 15, 32, 0, 0};
    vecs[3] = '{1'b1, 1'b0, 4'b1111, 16, 32, 4, 3};
    vecs[4] = '{1'b1, 1'b0, 4'b0000,  0, 12, 0, 0};
    vecs[5] = '{1'b1, 1'b1, 4'b0101,  7, 22, 2, 2};

    tick();
    tick();
    #1;
    check("reset_strobes", int'({busy, done, map_rd, dirty_clr, src_rd, dst_wr}), 0);
    check("reset_map_addr", int'(map_addr), 0);
    check("reset_src_addr", int'(src_addr), 0);
    check("reset_dst_addr", int'(dst_addr), 0);
    check("reset_dst_data", int'(dst_data), 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < 4; c++) dmask_m[c] = vecs[v].dmask[c];
      begin_render(vecs[v].md, vecs[v].key);
      finish_render(3);
      check("writes", wr_cnt, vecs[v].exp_wr);
      check("busy_cycles", busy_cnt, vecs[v].exp_busy);
      check("done_pulses", done_cnt, 1);
      check("dirty_clr_pulses", clr_cnt, vecs[v].exp_clr);
      if (vecs[v].exp_clr > 0) check("dirty_clr_addr", clr_addr, vecs[v].exp_clr_addr);
      check_fb(vecs[v].md, vecs[v].key, vecs[v].dmask);
      if (v == 0) begin
        check("cell10_px00_written", int'(fbw[2]), 1);
        check("cell10_px00_data", int'(fb[2]), 4);
      end
      if (v == 1) begin
        check("dirty_wr16", int'(fbw[16]), 1);
        check("dirty_wr17", int'(fbw[17]), 1);
        check("dirty_wr24", int'(fbw[24]), 1);
        check("dirty_wr25", int'(fbw[25]), 1);
      end
    end
    for (int c = 0; c < 4; c++) dmask_m[c] = 1'b0;

    // Backpressure: stall while cell (1,0) pixel 1 (src 5 -> dst 3) is on the bus.
    begin_render(1'b0, 1'b0);
    wait_busy(12);
    dst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_dst_wr", int'(dst_wr), 1);
      check("stall_dst_addr", int'(dst_addr), 3);
      check("stall_dst_data", int'(dst_data), 5);
      check("stall_src_rd", int'(src_rd), 0);
      tick();
    end
    dst_ready = 1'b1;
    finish_render(3);
    check("stall_writes", wr_cnt, 16);
    check("stall_busy_cycles", busy_cnt, 35);
    check_fb(1'b0, 1'b0, 4'b0000);

    // Reset during the second cell's blit.
    begin_render(1'b0, 1'b0);
    wait_busy(11);
    rst = 1'b1;
    tick();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_dst_wr", int'(dst_wr), 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("abort_no_done", done_cnt, 0);
    begin_render(1'b0, 1'b0);
    finish_render(3);
    check("after_abort_writes", wr_cnt, 16);
    check("after_abort_busy", busy_cnt, 32);
    check_fb(1'b0, 1'b0, 4'b0000);

    // start while busy is ignored.
    begin_render(1'b0, 1'b0);
    wait_busy(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_render(40);
    check("busy_start_done_pulses", done_cnt, 1);
    check("busy_start_writes", wr_cnt, 16);
    check("busy_start_busy_cycles", busy_cnt, 32);
    check_fb(1'b0, 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
